// File: rtl/game_pkg.sv
// Shared definitions for the copter cave game sequencer: FSM state encoding,
// screen geometry and score width.
package game_pkg;

    // Screen geometry in pixels.
    localparam int SCREEN_H = 480;
    localparam int SCREEN_W = 640;

    // Width of the score and hiscore counters.
    localparam int SCORE_W = 16;

    // Sequencer states, kept as plain 2-bit constants so older blocks that
    // compare against raw codes keep working.
    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t PLAY  = 2'd1;
    localparam state_t CRASH = 2'd2;
    localparam state_t OVER  = 2'd3;

    // Score increment that sticks at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value);
        if (value == {SCORE_W{1'b1}}) begin
            return value;
        end
        return value + 1'b1;
    endfunction

endpackage : game_pkg

// File: rtl/edge_detect.sv
// Registered 1-bit rising-edge detector. rise is high for one cycle, one
// clock after the input is first sampled high following a low sample.
// Suitable for any already-synchronised button or level input.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_prev;

    // Remember the previous sample and register the low-to-high transition.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_prev <= 1'b0;
            rise   <= 1'b0;
        end else begin
            d_prev <= d;
            rise   <= d & ~d_prev;
        end
    end

endmodule : edge_detect

// File: rtl/game_ctrl.sv
// Top-level game sequencer for the copter cave game.
// Arms the boundary generator, checks the copter against the cave walls once
// per frame, runs the crash-flash sequence and keeps the running score.
// Optional feature macro: GAME_CTRL_HISCORE_EN enables the best-score register;
// without it hiscore is tied to zero.
module game_ctrl
    import game_pkg::*;
#(
    parameter int GAP          = 300,
    parameter int COPTER_H     = 16,
    parameter int CRASH_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn,
    input  logic               frame_tick,
    input  logic [8:0]         copter_y,
    input  logic [8:0]         wall_top,
    output logic               start,
    output logic               gameover,
    output logic               restart,
    output logic               crash_flash,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hiscore
);

    localparam int CNT_W = $clog2(CRASH_FRAMES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRASH_FRAMES);
    localparam logic [9:0]       GAP_10   = 10'(GAP);
    localparam logic [9:0]       HEIGHT_10 = 10'(COPTER_H);
    localparam logic [9:0]       ROW_MAX  = 10'(SCREEN_H - 1);

    state_t           state;
    logic [CNT_W-1:0] crash_cnt;
    logic             btn_rise;

    logic [9:0] bot;
    logic [9:0] floor_row;
    logic       hit;

    // Registered rising edge of the player button.
    edge_detect u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .d     (btn),
        .rise  (btn_rise)
    );

    // Collision test in 10 bits so the sums cannot wrap: above the top wall,
    // below the bottom wall, or past the last visible row. Touching either
    // wall exactly is still inside the gap.
    always_comb begin
        bot       = {1'b0, copter_y} + HEIGHT_10;
        floor_row = {1'b0, wall_top} + GAP_10;
        hit       = (copter_y < wall_top) | (bot > floor_row) | (bot > ROW_MAX);
    end

    // Game sequencer: state, pulses, gameover, crash flash and score.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            crash_cnt   <= '0;
            start       <= 1'b0;
            restart     <= 1'b0;
            gameover    <= 1'b0;
            crash_flash <= 1'b0;
            score       <= '0;
        end else begin
            // Pulse outputs drop back to zero unless set below this cycle.
            start   <= 1'b0;
            restart <= 1'b0;

            case (state)
                IDLE: begin
                    if (btn_rise) begin
                        start <= 1'b1;
                        score <= '0;
                        state <= PLAY;
                    end
                end

                PLAY: begin
                    if (frame_tick) begin
                        if (hit) begin
                            gameover  <= 1'b1;
                            crash_cnt <= '0;
                            state     <= CRASH;
                        end else begin
                            score <= sat_inc(score);
                        end
                    end
                end

                CRASH: begin
                    // The count is checked one cycle after the last tick, so
                    // the final flash phase is visible before leaving.
                    if (crash_cnt == CNT_LAST) begin
                        crash_flash <= 1'b0;
                        state       <= OVER;
                    end else if (frame_tick) begin
                        crash_flash <= ~crash_flash;
                        crash_cnt   <= crash_cnt + 1'b1;
                    end
                end

                OVER: begin
                    if (btn_rise) begin
                        restart  <= 1'b1;
                        gameover <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef GAME_CTRL_HISCORE_EN
    // Best score so far, captured as a finished game is acknowledged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hiscore <= '0;
        end else if (state == OVER && btn_rise && score > hiscore) begin
            hiscore <= score;
        end
    end
`else
    // Best-score tracking not built.
    assign hiscore = '0;
`endif

endmodule : game_ctrl

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl, built with CRASH_FRAMES = 3.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_game_ctrl;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn = 1'b0;
    logic        frame_tick = 1'b0;
    logic [8:0]  copter_y = 9'd200;
    logic [8:0]  wall_top = 9'd90;
    logic        start;
    logic        gameover;
    logic        restart;
    logic        crash_flash;
    logic [15:0] score;
    logic [15:0] hiscore;

    int checks = 0;
    int passed = 0;

`ifdef GAME_CTRL_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    game_ctrl #(
        .GAP          (300),
        .COPTER_H     (16),
        .CRASH_FRAMES (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .frame_tick  (frame_tick),
        .copter_y    (copter_y),
        .wall_top    (wall_top),
        .start       (start),
        .gameover    (gameover),
        .restart     (restart),
        .crash_flash (crash_flash),
        .score       (score),
        .hiscore     (hiscore)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // One frame tick, sampled on the next falling edge.
    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Press: btn goes high; after two rising edges the sequencer has acted.
    task automatic press_and_check(input string tag, input bit is_restart);
        btn = 1'b1;
        @(negedge clk);
        check({tag, "_pulse_early"}, is_restart ? 32'(restart) : 32'(start), 0);
        @(negedge clk);
        check({tag, "_pulse"}, is_restart ? 32'(restart) : 32'(start), 1);
        btn = 1'b0;
        @(negedge clk);
        check({tag, "_pulse_end"}, is_restart ? 32'(restart) : 32'(start), 0);
    endtask

    // Three crash ticks, one cycle to enter OVER, then acknowledge.
    task automatic run_crash_and_restart(input string tag);
        repeat (3) tick();
        @(negedge clk);
        check({tag, "_over"}, 32'(dut.state), 32'(OVER));
        press_and_check({tag, "_restart"}, 1'b1);
        check({tag, "_idle"}, 32'(dut.state), 32'(IDLE));
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_start", 32'(start), 0);
        check("rst_gameover", 32'(gameover), 0);
        check("rst_score", 32'(score), 0);
        check("rst_hiscore", 32'(hiscore), 0);
        reset = 1'b1;
        @(negedge clk);

        // Game 1: start, then 10 scored frames.
        press_and_check("g1_start", 1'b0);
        check("g1_score0", 32'(score), 0);
        check("g1_gameover0", 32'(gameover), 0);
        wall_top = 9'd90;
        copter_y = 9'd200;
        repeat (10) tick();
        check("g1_score10", 32'(score), 10);
        check("g1_nogameover", 32'(gameover), 0);

        // Top wall: equal is safe, one above is a hit on that edge.
        copter_y = 9'd90;
        tick();
        check("top_equal_gameover", 32'(gameover), 0);
        check("top_equal_score", 32'(score), 11);
        copter_y = 9'd89;
        tick();
        check("top_hit_gameover", 32'(gameover), 1);
        check("top_hit_score", 32'(score), 11);

        // Crash sequence: flash 1,0,1 then 0 once in OVER.
        tick();
        check("flash1", 32'(crash_flash), 1);
        tick();
        check("flash2", 32'(crash_flash), 0);
        tick();
        check("flash3", 32'(crash_flash), 1);
        check("crash_state", 32'(dut.state), 32'(CRASH));
        @(negedge clk);
        check("over_state", 32'(dut.state), 32'(OVER));
        check("over_flash", 32'(crash_flash), 0);
        check("over_gameover", 32'(gameover), 1);
        tick();
        check("over_score_frozen", 32'(score), 11);
        press_and_check("g1_restart", 1'b1);
        check("g1_idle", 32'(dut.state), 32'(IDLE));
        check("g1_gameover_clr", 32'(gameover), 0);
        check("g1_score_kept", 32'(score), 11);
        check("g1_hiscore", 32'(hiscore), HI_EN ? 11 : 0);

        // Game 2: bottom wall exactly at floor is safe, one lower hits.
        press_and_check("g2_start", 1'b0);
        check("g2_score0", 32'(score), 0);
        wall_top = 9'd90;
        copter_y = 9'd374;
        tick();
        check("bot_equal_gameover", 32'(gameover), 0);
        check("bot_equal_score", 32'(score), 1);
        copter_y = 9'd375;
        tick();
        check("bot_hit_gameover", 32'(gameover), 1);
        check("bot_hit_score", 32'(score), 1);
        run_crash_and_restart("g2");
        check("g2_hiscore", 32'(hiscore), HI_EN ? 11 : 0);

        // Game 3: copter bottom past the last screen row.
        press_and_check("g3_start", 1'b0);
        wall_top = 9'd179;
        copter_y = 9'd464;
        tick();
        check("screen_hit_gameover", 32'(gameover), 1);
        check("screen_hit_score", 32'(score), 0);
        run_crash_and_restart("g3");

        // Game 4: a tick coinciding with the IDLE->PLAY edge is not scored.
        wall_top = 9'd90;
        copter_y = 9'd200;
        btn = 1'b1;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        btn = 1'b0;
        check("g4_start", 32'(start), 1);
        check("g4_tick_unscored", 32'(score), 0);
        tick();
        tick();
        check("g4_score2", 32'(score), 2);

        // Asynchronous reset between edges during PLAY.
        #2 reset = 1'b0;
        #1;
        check("arst_score", 32'(score), 0);
        check("arst_hiscore", 32'(hiscore), 0);
        check("arst_gameover", 32'(gameover), 0);
        check("arst_start", 32'(start), 0);
        check("arst_restart", 32'(restart), 0);
        check("arst_flash", 32'(crash_flash), 0);
        check("arst_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_state", 32'(dut.state), 32'(IDLE));
        check("post_rst_score", 32'(score), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_game_ctrl
